// File: rtl/rr_bus_arbiter.sv
// Four-requester round-robin bus arbiter with registered one-hot grant,
// bounded hold time and a one-cycle turnaround between tenures.
module rr_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
    localparam logic [HW-1:0] ONE_C      = HW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic            pick_found;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic            owner_done;
    logic            owner_req;
    logic            release_vol;
    logic            hold_expired;

    // Round-robin search starting just after the last winner; the final
    // candidate (k=4) wraps back onto ptr itself.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the current owner's done/req bits can end a tenure.
    always_comb begin
        owner_done   = done[gnt_id_q];
        owner_req    = req[gnt_id_q];
        release_vol  = owner_done | ~owner_req;
        hold_expired = (hold_cnt_q == MAX_HOLD_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (release_vol || hold_expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A release always lands in IDLE for one cycle, which gives the bus
    // turnaround; a voluntary release masks the timeout when both coincide.
    always_comb begin
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d      = 4'b0001 << pick_idx;
                    gnt_id_d   = pick_idx;
                    busy_d     = 1'b1;
                    ptr_d      = pick_idx;
                    hold_cnt_d = ONE_C;
                end else begin
                    gnt_d      = 4'b0000;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_vol || hold_expired) begin
                    gnt_d      = 4'b0000;
                    busy_d     = 1'b0;
                    hold_cnt_d = '0;
                    timeout_d  = ~release_vol & hold_expired;
                end else begin
                    hold_cnt_d = hold_cnt_q + ONE_C;
                end
            end
            default: begin
                gnt_d      = 4'b0000;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: reset, rotation, hold timeout,
// done/timeout collision, foreign done bits and mid-grant reset.
module tb_rr_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_bus_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are held through one rising edge; outputs are then sampled 1ns later.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBus(input string tag, input logic [3:0] eGnt, input logic [1:0] eId,
                            input logic eBusy, input logic eTo);
        checkOutput({tag, ".gnt"}, {4'b0, gnt}, {4'b0, eGnt});
        checkOutput({tag, ".busy"}, {7'b0, busy}, {7'b0, eBusy});
        checkOutput({tag, ".timeout"}, {7'b0, timeout}, {7'b0, eTo});
        if (eBusy) checkOutput({tag, ".id"}, {6'b0, gnt_id}, {6'b0, eId});
    endtask

    initial begin
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;

        // Reset state, with requests asserted to show reset wins.
        applyStimulus(4'b1111, 4'b0000);
        applyStimulus(4'b1111, 4'b1111);
        checkBus("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("reset.id", {6'b0, gnt_id}, 8'd0);
        rst = 1'b0;

        // Done bits in IDLE are ignored; no request keeps the bus idle.
        applyStimulus(4'b0000, 4'b1111);
        checkBus("idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);

        // req=0101 -> grant 0, release by done[0], turnaround, then grant 2.
        applyStimulus(4'b0101, 4'b0000);
        checkBus("r28_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0101, 4'b0001);
        checkBus("r28_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 4'b0000);
        checkBus("r28_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        checkBus("r28_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Re-reset so rotation starts at requester 0.
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000);
        rst = 1'b0;

        // Full contention: 3-cycle tenures separated by one idle cycle.
        for (int n = 0; n < 5; n++) begin
            for (int c = 1; c <= 3; c++) begin
                applyStimulus(4'b1111, 4'b0000);
                checkBus($sformatf("rot%0d_c%0d", n, c), 4'b0001 << order[n], order[n], 1'b1, 1'b0);
            end
            applyStimulus(4'b1111, 4'b0001 << order[n]);
            checkBus($sformatf("rot%0d_turn", n), 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Lone requester without done: 8 grant cycles, timeout pulse, regrant.
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b0010, 4'b0000);
            checkBus($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 4'b0000);
        checkBus("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'b0000);
        checkBus("hold_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done on the hold_cnt=8 cycle: release without timeout.
        for (int c = 2; c <= 8; c++) begin
            applyStimulus(4'b0010, 4'b0000);
        end
        checkBus("coll_c8", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b0010);
        checkBus("coll_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Foreign done and other req changes do not disturb owner 1.
        applyStimulus(4'b0010, 4'b0000);
        checkBus("own1_g", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b1000);
        checkBus("own1_done3", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b0000);
        checkBus("own1_nopre", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b1101, 4'b0000);
        checkBus("own1_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1101, 4'b0000);
        checkBus("next_g2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Reset in the middle of requester 2's tenure.
        applyStimulus(4'b1101, 4'b0000);
        checkBus("g2_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b0000);
        checkBus("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b1111, 4'b0000);
        checkBus("postrst_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
